multi_phase_clk_gen: RTL

Parametrised successor to the two-output divided clock generator. Produces NUM_CH phase-shifted divided clocks from the system clock. Used for multi-phase peripheral timing, e.g. non-overlapping shift/latch strobes. Outputs are tri-stated when idle; board or bench pull-ups hold them high. Stop is graceful: the current output period always completes before the lines are released.

---
 rtl/multi_phase_clk_gen_if.sv | 23 ++
 rtl/multi_phase_clk_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/multi_phase_clk_gen_if.sv
// Control/status bundle for multi_phase_clk_gen; the master drives the run request.
// The burst_len/done pair exists only when MULTI_PHASE_CLK_GEN_BURST_EN is defined.
interface multi_phase_clk_gen_if #(
    parameter int CNT_W = 16
) ();

    logic             en;
    logic             oe;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] periods;
`ifdef MULTI_PHASE_CLK_GEN_BURST_EN
    logic [CNT_W-1:0] burst_len;
    logic             done;

    modport master (output en, burst_len, input oe, busy, cnt, periods, done);
    modport slave  (input en, burst_len, output oe, busy, cnt, periods, done);
`else
    modport master (output en, input oe, busy, cnt, periods);
    modport slave  (input en, output oe, busy, cnt, periods);
`endif

endinterface

// File: rtl/multi_phase_clk_gen.sv
// NUM_CH phase-shifted 50% divided clocks with graceful stop and tri-stated idle outputs.
// Define MULTI_PHASE_CLK_GEN_BURST_EN to add a fixed-length burst mode (burst_len/done).
module multi_phase_clk_gen #(
    parameter int NUM_CH  = 2,
    parameter int CLK_DIV = 10,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    inout  wire  [NUM_CH-1:0]   clk_out,
    multi_phase_clk_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] DIV  = CNT_W'(CLK_DIV);
    localparam int               STEP = CLK_DIV / NUM_CH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  periods_q, periods_d;
    logic [NUM_CH-1:0] out_q, out_d;
    logic              oe_q, oe_d;
    logic              run_req;

    // Level of one channel at a given period position: low for the first half after its phase.
    function automatic logic phase_level(input logic [CNT_W-1:0] c, input int ch);
        logic [CNT_W-1:0] ph;
        logic [CNT_W-1:0] rel;
        ph  = CNT_W'(ch * STEP);
        rel = (c >= ph) ? (c - ph) : (c + (DIV - ph));
        return (rel >= HALF);
    endfunction

`ifdef MULTI_PHASE_CLK_GEN_BURST_EN
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             done_q, done_d;
    logic             burst_stop;

    // A nonzero burst forces the last period to drain regardless of en.
    always_comb begin
        burst_stop = (burst_q != '0) && (periods_q >= (burst_q - 1'b1));
        run_req    = bus.en && !burst_stop;
    end
`else
    assign run_req = bus.en;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            periods_q <= '0;
            out_q     <= '0;
            oe_q      <= 1'b0;
`ifdef MULTI_PHASE_CLK_GEN_BURST_EN
            burst_q   <= '0;
            done_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            periods_q <= periods_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
`ifdef MULTI_PHASE_CLK_GEN_BURST_EN
            burst_q   <= burst_d;
            done_q    <= done_d;
`endif
        end
    end

    // Leaving RUN/DRAIN is only allowed at the last count so periods are never truncated.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.en) state_d = RUN;
            end
            RUN, DRAIN: begin
                if (run_req)            state_d = RUN;
                else if (cnt_q == LAST) state_d = IDLE;
                else                    state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are precomputed from the next count so clk_out is fully registered.
    always_comb begin
        cnt_d     = cnt_q;
        periods_d = periods_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (state_d == RUN) periods_d = '0;
        end else begin
            cnt_d = (cnt_q == LAST) ? '0 : (cnt_q + 1'b1);
            if ((cnt_q == LAST) && (periods_q != '1)) periods_d = periods_q + 1'b1;
        end
        oe_d = (state_d != IDLE);
        for (int i = 0; i < NUM_CH; i++) begin
            out_d[i] = phase_level(cnt_d, i);
        end
`ifdef MULTI_PHASE_CLK_GEN_BURST_EN
        burst_d = ((state_q == IDLE) && (state_d == RUN)) ? bus.burst_len : burst_q;
        done_d  = (state_q != IDLE) && (state_d == IDLE) && burst_stop;
`endif
    end

    assign clk_out     = oe_q ? out_q : {NUM_CH{1'bz}};
    assign bus.oe      = oe_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.cnt     = cnt_q;
    assign bus.periods = periods_q;
`ifdef MULTI_PHASE_CLK_GEN_BURST_EN
    assign bus.done    = done_q;
`endif

endmodule
